pwm_deadtime_gen: RTL and testbench
===================================

Name: pwm_deadtime_gen

Overview:
- Downstream consumer of one phase-shifted carrier ramp, one per FCML switch-pair cell.
- Compares a period-synchronised duty reference against the ramp to form the raw PWM.
- Drives the complementary high/low gate signals with programmable dead time.
- Enable/fault forcing drives both gates off.

Parameters:
- RAMP_W, 11, width of ramp_ref and duty_ref.
- RAMP_MAX, 900, ramp peak count; ramp runs 0..RAMP_MAX and then wraps to 0.
- DT_CYCLES, 5, dead-time length in clk cycles; legal range 1..63.

Ports:
- clk  in  1  reference clock.
- rst  in  1  synchronous, active-low reset.
- ramp_ref  in  RAMP_W  carrier ramp from the ramp generator, unsigned.
- duty_ref  in  RAMP_W  requested compare level, unsigned.
- duty_valid  in  1  duty_ref is captured into the shadow register this cycle.
- en  in  1  gate enable; 0 forces the safe state.
- fault  in  1  hard fault; 1 forces the safe state.
- gate_hi  out  1  upper switch gate, registered.
- gate_lo  out  1  lower switch gate, registered.
- period_tick  out  1  one-cycle pulse on ramp wrap, registered.
- fault_status  out  1  fault indication, registered.

Behaviour:
- Reset (rst=0 at a clk edge): state=SAFE; gate_hi=0, gate_lo=0, period_tick=0, fault_status=0. duty_shadow, duty_active, ramp_prev, cmp_q and dt_cnt all cleared to 0.
- Reset mid-operation: gates are 0 after the same edge; no dead-time sequence is run.
- Clamp: duty_ref > RAMP_MAX+1 is stored as RAMP_MAX+1.
  - duty 0 gives a permanently low raw PWM.
  - RAMP_MAX+1 gives a permanently high raw PWM.
- Shadow: duty_valid=1 loads the clamped duty_ref into duty_shadow.
- Wrap detect: wrap = (ramp_ref < ramp_prev); ramp_prev <= ramp_ref every cycle.
- On wrap: duty_active <= clamped duty_ref if duty_valid=1 that cycle, else duty_shadow. period_tick=1 on the next edge.
- Compare: cmp_q <= (duty_active > ramp_ref), registered once. The compare uses duty_active before any update on the same edge.
- FSM states: SAFE, LO_ON, DT_LH, HI_ON, DT_HL. Gates are registered and updated on the same edge as the state, decoded from next state:
  - HI_ON: gate_hi=1.
  - LO_ON: gate_lo=1.
  - All other states: both gates 0.
- Priority 1: fault=1 or en=0 -> SAFE from any state, on the next edge.
- SAFE -> DT_HL when en=1 and fault=0 (and the latched fault is clear when the optional feature is compiled in).
- LO_ON -> DT_LH when cmp_q=1.
- HI_ON -> DT_HL when cmp_q=0.
- Dead-time counting: entering DT_LH or DT_HL loads dt_cnt=DT_CYCLES-1. The counter decrements each cycle in those states.
- Leaving dead time at dt_cnt==0: go to HI_ON if cmp_q=1, else LO_ON.
  - This applies to either DT state.
  - A raw edge that reverses during dead time returns to the prior side after the full dead time.
- Latency and the invariant:
  - A cmp_q change registered at edge k gives both gates 0 at edge k+1.
  - The new gate asserts at edge k+1+DT_CYCLES.
  - gate_hi and gate_lo are never both 1 in any cycle.
- fault_status = fault, registered.

Optional Feature:
- Macro: FCML_FAULT_LATCH_EN.
- Defined: fault=1 sets fault_latched. fault_latched is cleared only by reset. While it is set:
  - the FSM holds SAFE;
  - fault_status=1.
- Undefined: the fault is level-sensitive. Once fault=0 and en=1, SAFE exits to DT_HL; fault_status follows fault with a one-cycle delay.

Decomposition:
- Shared package fcml_pkg holds:
  - RAMP_W=11;
  - RAMP_MAX=900;
  - the FSM state enum pwm_state_t (SAFE, LO_ON, DT_LH, HI_ON, DT_HL);
  - gate-pair typedef gate_pair_t.
- One sub-module, pwm_duty_shadow, covers clamp, shadow, wrap detect, duty_active and period_tick.
- The FSM and dead-time counter stay in pwm_deadtime_gen.

Test Plan:
- Reset: hold rst=0 for 3 cycles with en=1 and a running ramp -> gate_hi=gate_lo=0, period_tick=0. Release, en=1 -> gate_lo=1 exactly 5 cycles after leaving SAFE.
- Steady PWM: duty=450, DT_CYCLES=5, ramp 0..900 -> per 901-cycle period, gate_hi high 445 cycles, gate_lo high 446 cycles, two 5-cycle both-low gaps, no overlap.
- Shadow sync: duty_valid pulse with 200 mid-period while active=450 -> the current period keeps 450; the next period after period_tick uses 200. duty_valid together with wrap -> the new value applies immediately.
- Extremes and clamp:
  - duty=0 -> gate_lo constant.
  - duty=2047 (clamped to 901) -> gate_hi constant after dead time.
  - Both cases: no gate toggling.
- Glitch: cmp_q high for 2 cycles only -> DT_LH runs 5 cycles, then returns to LO_ON; gate_hi never asserts.
- Fault:
  - fault=1 during HI_ON -> both gates 0 on the next edge.
  - Deassert fault -> re-entry via DT_HL (5 cycles) without FCML_FAULT_LATCH_EN.
  - With FCML_FAULT_LATCH_EN: stays SAFE with fault_status=1 until rst=0.

Source files
------------

// File: rtl/fcml_pkg.sv
// -----------------------------------------------------------------------------
// fcml_pkg
// Definitions shared by the FCML PWM dead-time generator slice:
//   RAMP_W      - width of the carrier ramp and duty reference
//   RAMP_MAX    - ramp peak count; the ramp runs 0..RAMP_MAX, then wraps to 0
//   pwm_state_t - gate sequencer states
//   gate_pair_t - complementary gate pair (hi = upper switch, lo = lower switch)
// -----------------------------------------------------------------------------
package fcml_pkg;

    localparam int RAMP_W   = 11;
    localparam int RAMP_MAX = 900;

    typedef enum logic [2:0] {
        SAFE  = 3'd0,
        LO_ON = 3'd1,
        DT_LH = 3'd2,
        HI_ON = 3'd3,
        DT_HL = 3'd4
    } pwm_state_t;

    typedef struct packed {
        logic hi;
        logic lo;
    } gate_pair_t;

endpackage

// File: rtl/pwm_deadtime_gen_if.sv
// -----------------------------------------------------------------------------
// pwm_deadtime_gen_if
// Signal bundle between one FCML switch-pair cell controller and its
// PWM/dead-time generator.
//   ramp_ref     : carrier ramp from the ramp generator (unsigned)
//   duty_ref     : requested compare level (unsigned)
//   duty_valid   : duty_ref is captured into the shadow register this cycle
//   en           : gate enable, 0 forces both gates off
//   fault        : hard fault, 1 forces both gates off
//   gate_hi      : upper switch gate
//   gate_lo      : lower switch gate
//   period_tick  : one-cycle pulse after each ramp wrap
//   fault_status : registered fault indication
// Modports: master drives references/controls; slave is the generator.
// -----------------------------------------------------------------------------
interface pwm_deadtime_gen_if
    import fcml_pkg::*;
#(
    parameter int RAMP_W = fcml_pkg::RAMP_W
);

    logic [RAMP_W-1:0] ramp_ref;
    logic [RAMP_W-1:0] duty_ref;
    logic              duty_valid;
    logic              en;
    logic              fault;
    logic              gate_hi;
    logic              gate_lo;
    logic              period_tick;
    logic              fault_status;

    modport master (
        output ramp_ref, duty_ref, duty_valid, en, fault,
        input  gate_hi, gate_lo, period_tick, fault_status
    );

    modport slave (
        input  ramp_ref, duty_ref, duty_valid, en, fault,
        output gate_hi, gate_lo, period_tick, fault_status
    );

endinterface

// File: rtl/pwm_duty_shadow.sv
// -----------------------------------------------------------------------------
// pwm_duty_shadow
// Period-synchronised duty reference. Requested duty is clamped to
// RAMP_MAX+1, held in a shadow register, and transferred to the active
// compare level only when the carrier ramp wraps, so a period never sees a
// mid-period duty change.
// Ports:
//   clk, rst     : clock, synchronous active-low reset
//   ramp_ref     : carrier ramp
//   duty_ref     : requested duty
//   duty_valid   : capture duty_ref this cycle
//   duty_active  : compare level in force for the current period
//   period_tick  : registered pulse, high for one cycle after a wrap
// -----------------------------------------------------------------------------
module pwm_duty_shadow
    import fcml_pkg::*;
#(
    parameter int RAMP_W   = fcml_pkg::RAMP_W,
    parameter int RAMP_MAX = fcml_pkg::RAMP_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RAMP_W-1:0] ramp_ref,
    input  logic [RAMP_W-1:0] duty_ref,
    input  logic              duty_valid,
    output logic [RAMP_W-1:0] duty_active,
    output logic              period_tick
);

    // RAMP_MAX+1 exceeds every ramp value, so it yields a permanently high PWM.
    localparam logic [RAMP_W-1:0] DUTY_LIM = RAMP_W'(RAMP_MAX + 1);

    logic [RAMP_W-1:0] duty_clamped;
    logic [RAMP_W-1:0] duty_shadow;
    logic [RAMP_W-1:0] ramp_prev;
    logic              wrap;

    // NOTE: every variable assigned in an always_comb gets a value on every
    // path (here unconditionally) so no latch is inferred.
    always_comb begin
        duty_clamped = (duty_ref > DUTY_LIM) ? DUTY_LIM : duty_ref;
        wrap         = (ramp_ref < ramp_prev);
    end

    // NOTE: reset is synchronous and active-low; it is sampled only at the
    // clock edge, so it is not in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst) begin
            duty_shadow <= '0;
            duty_active <= '0;
            ramp_prev   <= '0;
            period_tick <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading the
            // pre-edge values of its neighbours, independent of statement order.
            ramp_prev   <= ramp_ref;
            period_tick <= wrap;
            if (duty_valid) begin
                duty_shadow <= duty_clamped;
            end
            // A duty presented on the wrap cycle bypasses the shadow so it
            // takes effect for the period that is just starting.
            if (wrap) begin
                duty_active <= duty_valid ? duty_clamped : duty_shadow;
            end
        end
    end

endmodule

// File: rtl/pwm_deadtime_gen.sv
// -----------------------------------------------------------------------------
// pwm_deadtime_gen
// Complementary gate driver for one FCML switch-pair cell. The raw PWM is the
// registered comparison duty_active > ramp_ref; a five-state sequencer turns it
// into gate_hi/gate_lo with DT_CYCLES of both-off dead time on every side
// change. en=0 or fault=1 forces both gates off on the next edge.
// Ports:
//   clk  : reference clock
//   rst  : synchronous, active-low reset
//   bus  : pwm_deadtime_gen_if.slave (ramp/duty/controls in, gates/status out)
// Parameters:
//   RAMP_W, RAMP_MAX : ramp width and peak count
//   DT_CYCLES        : dead time in clk cycles, 1..63
// Build option:
//   FCML_FAULT_LATCH_EN - when defined, a fault latches until reset, holds the
//   gates off and keeps fault_status high. When undefined, the fault is
//   level-sensitive and fault_status is fault delayed by one cycle.
// -----------------------------------------------------------------------------
module pwm_deadtime_gen
    import fcml_pkg::*;
#(
    parameter int RAMP_W    = fcml_pkg::RAMP_W,
    parameter int RAMP_MAX  = fcml_pkg::RAMP_MAX,
    parameter int DT_CYCLES = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    pwm_deadtime_gen_if.slave      bus
);

    localparam logic [2:0] ST_SAFE  = SAFE;
    localparam logic [2:0] ST_LO_ON = LO_ON;
    localparam logic [2:0] ST_DT_LH = DT_LH;
    localparam logic [2:0] ST_HI_ON = HI_ON;
    localparam logic [2:0] ST_DT_HL = DT_HL;

    // The counter is loaded on entry and the exit happens on the cycle it
    // reads zero, giving exactly DT_CYCLES cycles in a dead-time state.
    localparam logic [5:0] DT_LOAD = 6'(DT_CYCLES - 1);

    logic [RAMP_W-1:0] duty_active;
    logic              period_tick;
    logic              cmp_q;
    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [5:0]        dt_cnt;
    logic              in_dt;
    logic              enter_dt;
    logic              hold_safe;
    logic              safe_req;
    logic              fault_flag;
    logic              fault_status;
    gate_pair_t        gates_nxt;
    gate_pair_t        gates_q;

    pwm_duty_shadow #(
        .RAMP_W   (RAMP_W),
        .RAMP_MAX (RAMP_MAX)
    ) u_duty_shadow (
        .clk         (clk),
        .rst         (rst),
        .ramp_ref    (bus.ramp_ref),
        .duty_ref    (bus.duty_ref),
        .duty_valid  (bus.duty_valid),
        .duty_active (duty_active),
        .period_tick (period_tick)
    );

`ifdef FCML_FAULT_LATCH_EN
    logic fault_latched;

    always_ff @(posedge clk) begin
        if (!rst) begin
            fault_latched <= 1'b0;
        end else if (bus.fault) begin
            fault_latched <= 1'b1;
        end
    end

    assign hold_safe = fault_latched;
`else
    assign hold_safe = 1'b0;
`endif

    assign safe_req   = bus.fault | ~bus.en | hold_safe;
    assign fault_flag = bus.fault | hold_safe;

    always_comb begin
        state_nxt = state;
        if (safe_req) begin
            state_nxt = ST_SAFE;
        end else begin
            case (state)
                ST_SAFE:  state_nxt = ST_DT_HL;
                ST_LO_ON: if (cmp_q)  state_nxt = ST_DT_LH;
                ST_HI_ON: if (!cmp_q) state_nxt = ST_DT_HL;
                // Side is chosen from the raw PWM at the end of dead time, so a
                // request that reverses mid dead time falls back to the old side.
                ST_DT_LH,
                ST_DT_HL: if (dt_cnt == 6'd0) state_nxt = cmp_q ? ST_HI_ON : ST_LO_ON;
                default:  state_nxt = ST_SAFE;
            endcase
        end

        in_dt    = (state == ST_DT_LH) || (state == ST_DT_HL);
        enter_dt = ((state_nxt == ST_DT_LH) || (state_nxt == ST_DT_HL)) && (state_nxt != state);

        // Gates are decoded from the next state so they change on the same edge
        // as the state register; only single-gate states can assert a gate,
        // which makes hi/lo overlap impossible.
        gates_nxt.hi = (state_nxt == ST_HI_ON);
        gates_nxt.lo = (state_nxt == ST_LO_ON);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ST_SAFE;
            gates_q      <= '0;
            dt_cnt       <= '0;
            cmp_q        <= 1'b0;
            fault_status <= 1'b0;
        end else begin
            state        <= state_nxt;
            gates_q      <= gates_nxt;
            cmp_q        <= (duty_active > bus.ramp_ref);
            fault_status <= fault_flag;
            if (enter_dt) begin
                dt_cnt <= DT_LOAD;
            end else if (in_dt && (dt_cnt != 6'd0)) begin
                dt_cnt <= dt_cnt - 6'd1;
            end
        end
    end

    assign bus.gate_hi      = gates_q.hi;
    assign bus.gate_lo      = gates_q.lo;
    assign bus.period_tick  = period_tick;
    assign bus.fault_status = fault_status;

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// -----------------------------------------------------------------------------
// tb_pwm_deadtime_gen
// Self-checking bench for pwm_deadtime_gen. A reference model describes the
// cell behaviourally: the raw PWM request is "duty in force > ramp", the gates
// follow the request except that any change of request, and any exit from the
// forced-off condition, blanks both gates for DT_CYCLES cycles before the gate
// matching the request at that moment is driven. The model pushes the expected
// outputs for every clock edge into a queue; a monitor pops and compares on the
// following falling edge. Directed phases add per-period gate counts.
// Honours FCML_FAULT_LATCH_EN when compiled with it.
// -----------------------------------------------------------------------------
module tb_pwm_deadtime_gen;
    import fcml_pkg::*;

    localparam int DT     = 5;
    localparam int LIM    = RAMP_MAX + 1;
    localparam int PERIOD = RAMP_MAX + 1;

    typedef struct {
        bit hi;
        bit lo;
        bit tick;
        bit fstat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   ramp_val = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    pwm_deadtime_gen_if bus ();

    pwm_deadtime_gen #(
        .RAMP_W    (RAMP_W),
        .RAMP_MAX  (RAMP_MAX),
        .DT_CYCLES (DT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_prev, m_shadow, m_active, m_dead;
    bit m_cmp, m_run, m_side, m_latched;

    always @(posedge clk) begin : model
        exp_t e;
        int   c;
        bit   wrap;
        bit   stop;
        e.hi = 1'b0;
        e.lo = 1'b0;
        e.tick = 1'b0;
        e.fstat = 1'b0;
        if (!rst) begin
            m_prev = 0; m_shadow = 0; m_active = 0; m_dead = 0;
            m_cmp = 1'b0; m_run = 1'b0; m_side = 1'b0; m_latched = 1'b0;
        end else begin
            c    = (int'(bus.duty_ref) > LIM) ? LIM : int'(bus.duty_ref);
            wrap = int'(bus.ramp_ref) < m_prev;
`ifdef FCML_FAULT_LATCH_EN
            stop    = bus.fault || !bus.en || m_latched;
            e.fstat = bus.fault || m_latched;
`else
            stop    = bus.fault || !bus.en;
            e.fstat = bus.fault;
`endif
            e.tick = wrap;
            // Gate behaviour: off while stopped; blank DT cycles on any restart
            // or request change; then drive the side the request names.
            if (stop) begin
                m_run  = 1'b0;
                m_dead = 0;
            end else if (!m_run) begin
                m_run  = 1'b1;
                m_dead = DT;
            end else if (m_dead > 0) begin
                m_dead--;
                if (m_dead == 0) m_side = m_cmp;
            end else if (m_cmp != m_side) begin
                m_dead = DT;
            end
            if (!stop && m_run && m_dead == 0) begin
                e.hi = m_side;
                e.lo = !m_side;
            end
            // Duty path: request uses the duty in force before this edge.
            m_cmp = m_active > int'(bus.ramp_ref);
            if (wrap) m_active = bus.duty_valid ? c : m_shadow;
            if (bus.duty_valid) m_shadow = c;
            m_prev = int'(bus.ramp_ref);
            if (bus.fault) m_latched = 1'b1;
        end
        exp_q.push_back(e);
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("gate_hi", bus.gate_hi, e.hi);
            check("gate_lo", bus.gate_lo, e.lo);
            check("period_tick", bus.period_tick, e.tick);
            check("fault_status", bus.fault_status, e.fstat);
            check("no_overlap", bus.gate_hi & bus.gate_lo, 0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_ramp(input int r);
        @(negedge clk);
        ramp_val       = r;
        bus.ramp_ref   = RAMP_W'(r);
        bus.duty_valid = 1'b0;
    endtask

    task automatic cyc();
        drive_ramp((ramp_val == RAMP_MAX) ? 0 : ramp_val + 1);
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic load_duty(input int d);
        bus.duty_ref   = RAMP_W'(d);
        bus.duty_valid = 1'b1;
    endtask

    task automatic run_to(input int r);
        int k = 0;
        while (ramp_val != r && k < 2 * PERIOD) begin
            cyc();
            k++;
        end
        if (ramp_val != r) check("run_to_bound", ramp_val, r);
    endtask

    task automatic measure(input int n, output int hi_n, output int lo_n,
                           output int off_n, output int toggles);
        logic [1:0] prev;
        logic [1:0] cur;
        hi_n = 0; lo_n = 0; off_n = 0; toggles = 0;
        prev = {bus.gate_hi, bus.gate_lo};
        repeat (n) begin
            cyc();
            cur = {bus.gate_hi, bus.gate_lo};
            hi_n  += int'(cur[1]);
            lo_n  += int'(cur[0]);
            off_n += int'(cur == 2'b00);
            if (cur != prev) toggles++;
            prev = cur;
        end
    endtask

    function automatic int pick_duty();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, 2047));
            1:       return int'($urandom_range(0, LIM));
            2:       return ($urandom_range(0, 1) == 1) ? LIM : 0;
            default: return int'($urandom_range(LIM - 3, LIM + 3));
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int hi_n, lo_n, off_n, tg, n, hi_seen, off_seen, fault_len, en_len;

        rst            = 1'b0;
        bus.en         = 1'b1;
        bus.fault      = 1'b0;
        bus.duty_ref   = '0;
        bus.duty_valid = 1'b0;
        bus.ramp_ref   = '0;

        // Reset held with the ramp running and en=1.
        run(3);
        check("reset_outputs",
              {28'd0, bus.gate_hi, bus.gate_lo, bus.period_tick, bus.fault_status}, 0);
        rst = 1'b1;
        // First sample follows the edge that leaves SAFE; gate_lo arrives
        // DT edges after that one.
        n = 0;
        do begin
            cyc();
            n++;
        end while (!bus.gate_lo && n < 40);
        check("lo_after_reset_dt", n, DT + 1);

        // Steady PWM at duty 450.
        load_duty(450);
        run(3 * PERIOD);
        measure(PERIOD, hi_n, lo_n, off_n, tg);
        check("steady_hi_cycles", hi_n, 445);
        check("steady_lo_cycles", lo_n, 446);
        check("steady_off_cycles", off_n, 2 * DT);
        check("steady_toggles", tg, 4);

        // Mid-period duty change waits for the wrap.
        run_to(300);
        load_duty(200);
        run(2 * PERIOD);
        measure(PERIOD, hi_n, lo_n, off_n, tg);
        check("shadow_hi_cycles", hi_n, 200 - DT);
        check("shadow_lo_cycles", lo_n, PERIOD - 200 - DT);

        // Duty presented on the wrap cycle applies to the period just starting.
        run_to(0);
        load_duty(600);
        measure(PERIOD, hi_n, lo_n, off_n, tg);
        check("wrap_load_hi_cycles", hi_n, 600 - DT);
        check("wrap_load_lo_cycles", lo_n, PERIOD - 600 - DT);

        // Extremes: duty 0 and clamped 2047.
        load_duty(0);
        run(2 * PERIOD + 10);
        measure(PERIOD, hi_n, lo_n, off_n, tg);
        check("duty0_lo_cycles", lo_n, PERIOD);
        check("duty0_toggles", tg, 0);
        load_duty(2047);
        run(2 * PERIOD + 10);
        measure(PERIOD, hi_n, lo_n, off_n, tg);
        check("clamp_hi_cycles", hi_n, PERIOD);
        check("clamp_toggles", tg, 0);

        // Two-cycle raw PWM glitch during LO_ON.
        load_duty(450);
        run(2 * PERIOD);
        run_to(700);
        check("glitch_pre_lo", bus.gate_lo, 1);
        hi_seen  = 0;
        off_seen = 0;
        drive_ramp(100);
        hi_seen += int'(bus.gate_hi); off_seen += int'(!bus.gate_hi && !bus.gate_lo);
        drive_ramp(100);
        hi_seen += int'(bus.gate_hi); off_seen += int'(!bus.gate_hi && !bus.gate_lo);
        drive_ramp(703);
        hi_seen += int'(bus.gate_hi); off_seen += int'(!bus.gate_hi && !bus.gate_lo);
        repeat (30) begin
            cyc();
            hi_seen  += int'(bus.gate_hi);
            off_seen += int'(!bus.gate_hi && !bus.gate_lo);
        end
        check("glitch_hi_never", hi_seen, 0);
        check("glitch_dead_cycles", off_seen, DT);
        check("glitch_back_lo", bus.gate_lo, 1);

        // Randomised duty updates, enable drops and fault pulses.
        fault_len = 0;
        en_len    = 0;
        repeat (4000) begin
            cyc();
            if ($urandom_range(0, 99) < 3) load_duty(pick_duty());
            if (fault_len == 0 && $urandom_range(0, 599) == 0) fault_len = int'($urandom_range(1, 8));
            if (en_len == 0 && $urandom_range(0, 599) == 0) en_len = int'($urandom_range(1, 20));
            bus.fault = (fault_len > 0);
            if (fault_len > 0) fault_len--;
            bus.en = (en_len == 0);
            if (en_len > 0) en_len--;
        end
        bus.fault = 1'b0;
        bus.en    = 1'b1;

        // Mid-operation reset, then fault while HI_ON.
        cyc();
        rst = 1'b0;
        run(2);
        rst = 1'b1;
        load_duty(2047);
        run(2 * PERIOD + 10);
        check("fault_pre_hi", bus.gate_hi, 1);
        bus.fault = 1'b1;
        cyc();
        check("fault_gates_off", {30'd0, bus.gate_hi, bus.gate_lo}, 0);
        run(3);
        bus.fault = 1'b0;
`ifdef FCML_FAULT_LATCH_EN
        run(20);
        check("latch_gates_off", {30'd0, bus.gate_hi, bus.gate_lo}, 0);
        check("latch_status", bus.fault_status, 1);
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        check("latch_cleared", bus.fault_status, 0);
`else
        n = 0;
        do begin
            cyc();
            n++;
        end while (!bus.gate_hi && n < 40);
        check("fault_reentry_dt", n, DT + 1);
        check("fault_status_clear", bus.fault_status, 0);
`endif
        run(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
